// File: rtl/bus_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_drive_arbiter
// Brief    : Round-robin arbiter granting the shared datapath bus to exactly
//            one requesting source. One dead (gap) cycle is always inserted
//            between owners so two sources never drive the bus together.
//            The one-hot grant feeds the downstream 32-to-5 select encoder;
//            grant_idx carries the same selection in binary.
// Config   : BUS_ARB_FIXED_PRIO_EN - when defined, the lowest requesting
//            index always wins (no rotating pointer). Burst preemption still
//            applies and hands the bus to the lowest *other* requester.
// Revision : 1.0 - initial release
// ============================================================================
module bus_drive_arbiter #(
  parameter int N_SRC     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [N_SRC-1:0] req,
  input  logic             lock,
  output logic [N_SRC-1:0] grant,
  output logic [4:0]       grant_idx,
  output logic             grant_vld
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [N_SRC-1:0] c_ONE     = {{(N_SRC-1){1'b0}}, 1'b1};
  localparam logic [7:0]       c_CNT_MAX = 8'hFF;
  localparam logic [4:0]       c_LAST    = 5'(N_SRC - 1);

  state_t           r_state;
  logic [N_SRC-1:0] r_grant;
  logic [4:0]       r_grant_idx;
  logic             r_grant_vld;
  logic [7:0]       r_burst_cnt;

  logic [N_SRC-1:0] w_cand;
  logic             w_pick_vld;
  logic [4:0]       w_pick_idx;
  logic             w_own_req;
  logic             w_others;
  logic             w_force;
  logic [4:0]       w_next_ptr;

`ifdef BUS_ARB_FIXED_PRIO_EN
  // Previous owner after a forced release; excluded from the following
  // arbitration so preemption actually passes the bus to someone else.
  logic [N_SRC-1:0] r_excl;

  // Candidates: every request except a just-preempted owner
  always_comb begin
    w_cand = req & ~r_excl;
  end

  // Fixed priority: lowest candidate index wins
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = 5'(i);
      end
    end
  end
`else
  logic [4:0]         r_ptr;
  logic [2*N_SRC-1:0] w_rot;
  logic [4:0]         w_off;
  logic [5:0]         w_sum;

  // Candidates: all requests (no latching of dropped requests)
  always_comb begin
    w_cand = req;
  end

  // Round robin: rotate so ptr sits at bit 0, find first set bit, map back
  always_comb begin
    w_rot      = {w_cand, w_cand} >> r_ptr;
    w_pick_vld = 1'b0;
    w_off      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!w_pick_vld && w_rot[i]) begin
        w_pick_vld = 1'b1;
        w_off      = 5'(i);
      end
    end
    w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    w_pick_idx = (w_sum >= 6'(N_SRC)) ? 5'(w_sum - 6'(N_SRC)) : w_sum[4:0];
  end
`endif

  // Owner status: still requesting, competing requests, and burst preemption
  always_comb begin
    w_own_req  = |(req & r_grant);
    w_others   = |(req & ~r_grant);
    w_force    = !lock && (MAX_BURST != 0) &&
                 (int'(r_burst_cnt) >= MAX_BURST) && w_others;
    w_next_ptr = (r_grant_idx == c_LAST) ? 5'd0 : r_grant_idx + 5'd1;
  end

  // Arbiter FSM with registered grant outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_grant_vld <= 1'b0;
      r_burst_cnt <= '0;
`ifdef BUS_ARB_FIXED_PRIO_EN
      r_excl      <= '0;
`else
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_pick_vld) begin
            r_grant     <= c_ONE << w_pick_idx;
            r_grant_idx <= w_pick_idx;
            r_grant_vld <= 1'b1;
            r_burst_cnt <= 8'd1;
            r_state     <= ST_OWN;
          end else begin
            r_state     <= ST_IDLE;
          end
`ifdef BUS_ARB_FIXED_PRIO_EN
          r_excl <= '0;
`endif
        end
        ST_OWN: begin
          if (!w_own_req || w_force) begin
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_state     <= ST_GAP;
`ifdef BUS_ARB_FIXED_PRIO_EN
            r_excl      <= w_own_req ? r_grant : '0;
`else
            r_ptr       <= w_next_ptr;
`endif
          end else if (r_burst_cnt != c_CNT_MAX) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_grant     <= '0;
          r_grant_vld <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign grant_vld = r_grant_vld;

endmodule
`default_nettype wire

// File: tb/tb_bus_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_drive_arbiter
// Brief    : Self-checking bench for bus_drive_arbiter (round-robin build).
//            A behavioural model tracks owner, run length and rotating
//            pointer; directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_drive_arbiter;

  localparam int N    = 32;
  localparam int MAXB = 8;

  logic          clk;
  logic          clr_n;
  logic [N-1:0]  req;
  logic          lock;
  logic [N-1:0]  grant;
  logic [4:0]    grant_idx;
  logic          grant_vld;

  int n_cmp;
  int n_err;

  // Reference model state
  int m_owner;   // -1 when nobody owns the bus
  int m_ptr;
  int m_run;
  int m_idx;

  bus_drive_arbiter #(
    .N_SRC     (N),
    .MAX_BURST (MAXB)
  ) u_dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_run   = 0;
    m_idx   = 0;
  endfunction

  // One clock edge of the arbitration rules, using req/lock seen at the edge
  function automatic void model_edge(input logic [N-1:0] r, input logic lk);
    int  pick;
    bit  others;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int k = 0; k < N; k++)
        if (k != m_owner && r[k]) others = 1'b1;
      if (!r[m_owner] || (!lk && MAXB != 0 && m_run >= MAXB && others)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_run < 255) begin
        m_run++;
      end
    end else begin
      // idle or gap: first requester at or after ptr, wrapping
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && r[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      if (pick >= 0) begin
        m_owner = pick;
        m_idx   = pick;
        m_run   = 1;
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, ".grant"}, grant, eg);
    chk({tag, ".idx"}, {27'd0, grant_idx}, m_idx);
    chk({tag, ".vld"}, {31'd0, grant_vld}, {31'd0, (m_owner >= 0)});
    chk({tag, ".onehot"}, {31'd0, $onehot0(grant)}, 32'd1);
  endtask

  // Inputs are applied at the negedge; the model steps at posedge and the
  // DUT outputs are compared at the following negedge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(req, lock);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_n = 1'b0;
    req   = '0;
    lock  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    clr_n = 1'b1;

    // Idle with no requests
    repeat (5) step("idle");

    // Single requester, then drop
    req = 32'h0000_0010;
    step("single_grant");
    chk("single_idx4", {27'd0, grant_idx}, 32'd4);
    repeat (3) step("single_hold");
    req = '0;
    step("single_drop");
    repeat (2) step("single_idle");

    // Two requesters, burst preemption alternates 0,gap,2,gap
    req = 32'h0000_0005;
    repeat (40) step("burst");

    // Lock: current owner keeps the bus past counter saturation
    lock = 1'b1;
    repeat (300) step("lock");
    lock = 1'b0;
    req  = '0;
    repeat (3) step("unlock_drop");

    // Wrap: src31 owns, src1 joins; after preemption src1 then src31 again
    req = 32'h8000_0000;
    repeat (3) step("wrap_pre");
    req = 32'h8000_0002;
    repeat (30) step("wrap");

    // Asynchronous reset while src8 owns the bus
    req = 32'h0000_0100;
    repeat (3) step("pre_rst");
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_rst.grant", grant, 32'd0);
    chk("async_rst.vld", {31'd0, grant_vld}, 32'd0);
    chk("async_rst.idx", {27'd0, grant_idx}, 32'd0);
    model_reset();
    @(negedge clk);
    req   = 32'h0000_0101;
    clr_n = 1'b1;
    step("post_rst_first");
    chk("post_rst_src0", grant, 32'h0000_0001);
    repeat (20) step("post_rst");

    // Random traffic: a few hot sources, occasional lock
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req = N'($urandom) & N'($urandom);
          1: req = N'(1) << $urandom_range(0, N - 1);
          2: req = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
          default: req = N'($urandom);
        endcase
      end
      lock = ($urandom_range(0, 9) == 0);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
